// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot delay, fetch stalls, branch/JAL/JALR
// redirects, misaligned-target trap and EBREAK-style halt/resume.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h00000100,
  parameter int          BOOT_DELAY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jalr_en,
  input  logic [31:0] jalr_base,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        fetch_valid,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10,
    TRAP = 2'b11
  } state_t;

  localparam int CW = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

  state_t        st;
  state_t        nst;
  logic [CW-1:0] cnt;
  logic [31:0]   inc;
  logic [31:0]   jtgt;
  logic [31:0]   sel;
  logic          mis;
  logic          commit;

  // Target selection: halt beats jalr beats branch beats sequential.
  always_comb begin
    inc  = pc + 32'd4;
    jtgt = jalr_base & ~32'h1;
    sel  = inc;
    nst  = RUN;
    mis  = 1'b0;
    if (halt_req) begin
      nst = HALT;
    end else if (jalr_en) begin
      if (jtgt[1:0] != 2'b00) begin
        mis = 1'b1;
        sel = TRAP_VECTOR;
        nst = TRAP;
      end else begin
        sel = jtgt;
      end
    end else if (branch_taken) begin
      if (branch_target[1:0] != 2'b00) begin
        mis = 1'b1;
        sel = TRAP_VECTOR;
        nst = TRAP;
      end else begin
        sel = branch_target;
      end
    end
  end

  assign commit      = (st == RUN) && imem_ready;
  assign next_pc     = commit ? sel : pc;
  assign fetch_valid = commit;
  assign trap        = (st == TRAP);
  assign state       = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_VECTOR;
      st      <= BOOT;
      cnt     <= CW'(BOOT_DELAY);
      trap_pc <= 32'h0;
    end else begin
      unique case (st)
        BOOT: begin
          if (cnt == '0) st <= RUN;
          else           cnt <= cnt - 1'b1;
        end
        RUN: begin
          if (imem_ready) begin
            pc <= sel;
            st <= nst;
            if (mis) trap_pc <= pc;
          end
        end
        HALT: begin
          if (resume) st <= RUN;
        end
        TRAP: st <= RUN;
        default: st <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stall, redirects, trap, halt,
// wrap-around and asynchronous reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jalr_en;
  logic [31:0] jalr_base;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        fetch_valid;
  logic        trap;
  logic [31:0] trap_pc;
  logic [1:0]  state;

  int n_vec = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jalr_en      (jalr_en),
    .jalr_base    (jalr_base),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc           (pc),
    .next_pc      (next_pc),
    .fetch_valid  (fetch_valid),
    .trap         (trap),
    .trap_pc      (trap_pc),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic br,
                       input logic [31:0] bt, input logic jr,
                       input logic [31:0] jb, input logic hr,
                       input logic rs);
    imem_ready    = rdy;
    branch_taken  = br;
    branch_target = bt;
    jalr_en       = jr;
    jalr_base     = jb;
    halt_req      = hr;
    resume        = rs;
    #1;
  endtask

  task automatic step_seq(input logic [31:0] exp_pc);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("seq_pc", pc, exp_pc);
  endtask

  task automatic jump(input logic [31:0] tgt);
    drive(1, 1, tgt, 0, 0, 0, 0);
    tick();
    chk("jump_pc", pc, tgt);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);
    chk("rst_fv", 32'(fetch_valid), 32'h0);
    tick();
    chk("rst_hold_state", 32'(state), 32'h0);

    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("boot_fv", 32'(fetch_valid), 32'h0);
    chk("boot_next_pc", next_pc, 32'h0);
    tick();
    chk("boot1_state", 32'(state), 32'h0);
    tick();
    chk("boot2_state", 32'(state), 32'h0);
    chk("boot2_pc", pc, 32'h0);
    tick();
    chk("boot3_state", 32'(state), 32'h1);
    chk("boot3_pc", pc, 32'h0);

    drive(1, 0, 0, 0, 0, 0, 0);
    chk("run_fv", 32'(fetch_valid), 32'h1);
    chk("run_next_pc", next_pc, 32'h4);
    step_seq(32'h4);
    step_seq(32'h8);
    step_seq(32'hC);

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h40, 0, 0, 0, 0);
      chk("stall_fv", 32'(fetch_valid), 32'h0);
      chk("stall_next_pc", next_pc, 32'hC);
      tick();
      chk("stall_pc", pc, 32'hC);
      chk("stall_state", 32'(state), 32'h1);
    end
    drive(1, 1, 32'h40, 0, 0, 0, 0);
    chk("br_next_pc", next_pc, 32'h40);
    tick();
    chk("br_pc", pc, 32'h40);

    drive(1, 1, 32'h80, 1, 32'h201, 0, 0);
    chk("jalr_next_pc", next_pc, 32'h200);
    tick();
    chk("jalr_pc", pc, 32'h200);

    jump(32'h10);
    drive(1, 0, 0, 1, 32'h102, 0, 0);
    chk("mis_next_pc", next_pc, 32'h100);
    tick();
    chk("trap_state", 32'(state), 32'h3);
    chk("trap_flag", 32'(trap), 32'h1);
    chk("trap_pc", trap_pc, 32'h10);
    chk("trap_pcv", pc, 32'h100);
    drive(1, 1, 32'h44, 0, 0, 0, 1);
    chk("trap_fv", 32'(fetch_valid), 32'h0);
    chk("trap_next_pc", next_pc, 32'h100);
    tick();
    chk("post_trap_state", 32'(state), 32'h1);
    chk("post_trap_flag", 32'(trap), 32'h0);
    chk("post_trap_pc", pc, 32'h100);

    jump(32'h20);
    drive(1, 1, 32'h80, 1, 32'h300, 1, 0);
    chk("halt_next_pc", next_pc, 32'h24);
    tick();
    chk("halt_pc", pc, 32'h24);
    chk("halt_state", 32'(state), 32'h2);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("halt_fv", 32'(fetch_valid), 32'h0);
      tick();
      chk("halt_hold_pc", pc, 32'h24);
      chk("halt_hold_state", 32'(state), 32'h2);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("resume_state", 32'(state), 32'h1);
    chk("resume_pc", pc, 32'h24);
    step_seq(32'h28);

    drive(1, 1, 32'h32, 0, 0, 0, 0);
    tick();
    chk("br_mis_state", 32'(state), 32'h3);
    chk("br_mis_trap_pc", trap_pc, 32'h28);
    chk("br_mis_pc", pc, 32'h100);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("br_mis_recover", 32'(state), 32'h1);

    jump(32'hFFFFFFFC);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("wrap_next_pc", next_pc, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_state", 32'(state), 32'h1);
    chk("wrap_trap", 32'(trap), 32'h0);

    step_seq(32'h4);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("pre_rst_pc", pc, 32'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_state", 32'(state), 32'h0);
    tick();
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reboot_state_b", 32'(state), 32'h0);
    tick();
    chk("reboot_state_r", 32'(state), 32'h1);
    step_seq(32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
